// File: rtl/tdc_pkg.sv
// Shared definitions for the synchronous time-to-digital converter.
// Holds the fixed datapath widths, the timeout result code and the FSM
// state encoding used by tdc_top_sync.
package tdc_pkg;

  localparam int PHASE_W  = 32;
  localparam int COARSE_W = 8;
  localparam int FINE_W   = 5;
  localparam int TOF_W    = 13;

  // Result reported when no stop arrives before the coarse counter saturates.
  localparam logic [TOF_W-1:0]    TOF_TIMEOUT = 13'h1FFF;
  localparam logic [COARSE_W-1:0] COARSE_MAX  = 8'd255;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/tdc_edge_sync.sv
// Two-flop synchroniser plus one delay flop and a rising-edge detector for
// an asynchronous level input.
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-low reset, clears all three flops
//   din  - asynchronous level input
//   evt  - one-cycle pulse, high for the cycle after din is seen high in the
//          second synchroniser stage while the third stage is still low
module tdc_edge_sync
  import tdc_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic evt
);

  // sr[0], sr[1]: metastability synchroniser; sr[2]: delay stage for edge detect.
  logic [2:0] sr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr <= 3'b000;
    end else begin
      sr <= {sr[1:0], din};
    end
  end

  assign evt = sr[1] & ~sr[2];

endmodule

// File: rtl/tdc_top_sync.sv
// Synchronous time-to-digital converter. Measures the interval from a start
// rising edge to a light_pulse (stop) rising edge as a coarse clk-cycle count
// plus a 5-bit fine interpolation taken from a 32-tap thermometer phase vector.
// Ports:
//   clk         - system clock, all state on the rising edge
//   rst         - asynchronous active-low reset
//   phase       - thermometer snapshot of 32 clock phases (one run of 1s)
//   start       - asynchronous start level, rising edge starts a measurement
//   light_pulse - asynchronous stop level, rising edge ends a measurement
//   tof         - {coarse[7:0], fine[4:0]}, LSB = Tclk/32, holds between results
//   out_valid   - one-cycle pulse when tof is updated
// Handshake: out_valid is a push-only strobe with no ready; the consumer must
// capture tof in the cycle out_valid is high (tof also holds afterwards).
module tdc_top_sync
  import tdc_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [PHASE_W-1:0] phase,
  input  logic               start,
  input  logic               light_pulse,
  output logic [TOF_W-1:0]   tof,
  output logic               out_valid
);

  // Lowest index where a 1 follows a 0 (wrap-aware start of the 1s run).
  // Uniform vectors have no such transition and decode to 0.
  function automatic logic [FINE_W-1:0] fine_decode(input logic [PHASE_W-1:0] p);
    logic [FINE_W-1:0] f;
    f = '0;
    for (int i = PHASE_W - 1; i >= 0; i--) begin
      if (p[i] && !p[(i + PHASE_W - 1) % PHASE_W]) begin
        f = FINE_W'(i);
      end
    end
    return f;
  endfunction

  logic                start_evt;
  logic                stop_evt;
  logic [FINE_W-1:0]   fine_now;
  logic [FINE_W-1:0]   fine_start;
  logic [COARSE_W-1:0] cnt;
  logic [TOF_W-1:0]    tof_calc;
  state_t              state;

  tdc_edge_sync u_start_sync (
    .clk (clk),
    .rst (rst),
    .din (start),
    .evt (start_evt)
  );

  tdc_edge_sync u_stop_sync (
    .clk (clk),
    .rst (rst),
    .din (light_pulse),
    .evt (stop_evt)
  );

  assign fine_now = fine_decode(phase);

  // Both events share the same synchroniser latency, so the coarse count and
  // the fine difference can be combined directly; the 13-bit width gives the
  // required modulo-8192 wrap when fine_stop < fine_start.
  assign tof_calc = {cnt, {FINE_W{1'b0}}} + TOF_W'(fine_now) - TOF_W'(fine_start);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      fine_start <= '0;
      tof        <= '0;
      out_valid  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          // Start takes priority; a coincident stop is simply dropped.
          if (start_evt) begin
            fine_start <= fine_now;
            cnt        <= 8'd1;
            state      <= RUN;
          end
        end
        RUN: begin
          if (stop_evt) begin
            tof       <= tof_calc;
            out_valid <= 1'b1;
            cnt       <= '0;
            state     <= IDLE;
          end else if (cnt == COARSE_MAX) begin
            tof       <= TOF_TIMEOUT;
            out_valid <= 1'b1;
            cnt       <= '0;
            state     <= IDLE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tdc_top_sync.sv
// Directed self-checking bench for tdc_top_sync.
module tb_tdc_top_sync;

  logic        clk;
  logic        rst;
  logic [31:0] phase;
  logic        start;
  logic        light_pulse;
  logic [12:0] tof;
  logic        out_valid;

  int          n_pass;
  int          n_total;
  int          valid_cnt;
  int          dbl_cnt;
  logic        prev_valid;
  logic [12:0] last_tof;
  logic        rot_en;
  logic [4:0]  rot_idx;
  logic [31:0] rot_base;
  int          lat;

  tdc_top_sync dut (
    .clk         (clk),
    .rst         (rst),
    .phase       (phase),
    .start       (start),
    .light_pulse (light_pulse),
    .tof         (tof),
    .out_valid   (out_valid)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Advance to the next falling edge, update a rotating phase if enabled,
  // and record any out_valid pulse seen there.
  task automatic tick();
    int sh;
    @(negedge clk);
    if (rot_en) begin
      sh    = int'(rot_idx);
      phase = (sh == 0) ? rot_base : ((rot_base >> sh) | (rot_base << (32 - sh)));
      rot_idx = rot_idx + 5'd1;
    end
    if (out_valid === 1'b1) begin
      valid_cnt++;
      last_tof = tof;
      if (prev_valid === 1'b1) dbl_cnt++;
    end
    prev_valid = out_valid;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Start rise, stop rise n cycles later, then check latency and result.
  // with_stop: stop also rises together with start (must be dropped).
  // restart: a second start rise during RUN (must be ignored), needs n >= 30.
  task automatic meas(input int n, input logic [12:0] exp, input string tag,
                      input bit with_stop, input bit restart);
    valid_cnt = 0;
    start = 1'b1;
    if (with_stop) light_pulse = 1'b1;
    for (int i = 1; i <= n; i++) begin
      tick();
      if (i == 4) begin
        start = 1'b0;
        light_pulse = 1'b0;
      end
      if (restart && i == 20) start = 1'b1;
      if (restart && i == 24) start = 1'b0;
    end
    start = 1'b0;
    light_pulse = 1'b1;
    ticks(2);
    chk({tag, "_early"}, valid_cnt, 0);
    tick();
    chk({tag, "_valid"}, valid_cnt, 1);
    chk({tag, "_tof"}, tof, exp);
    ticks(2);
    light_pulse = 1'b0;
    ticks(4);
    chk({tag, "_single"}, valid_cnt, 1);
  endtask

  initial begin
    n_pass = 0; n_total = 0; valid_cnt = 0; dbl_cnt = 0;
    prev_valid = 1'b0; last_tof = '0;
    rot_en = 1'b0; rot_idx = '0; rot_base = 32'hFFFF0000;
    rst = 1'b0; start = 1'b0; light_pulse = 1'b0;
    phase = 32'hFFFF0000;

    // reset held with toggling inputs
    for (int i = 0; i < 6; i++) begin
      start = i[1];
      light_pulse = i[0];
      tick();
      chk("reset_outputs", {18'd0, out_valid, tof}, 32'd0);
    end
    start = 1'b0; light_pulse = 1'b0;
    ticks(3);
    rst = 1'b1;
    valid_cnt = 0;
    ticks(10);
    chk("idle_no_valid", valid_cnt, 0);

    // static phase, fine = 16 both ends
    meas(110, 13'd3520, "static", 1'b0, 1'b0);

    // minimum interval N = 1
    meas(1, 13'd32, "min_n1", 1'b0, 1'b0);

    // fine difference: 16 at start, 20 at stop, N = 3
    valid_cnt = 0;
    phase = 32'hFFFF0000;
    start = 1'b1;
    ticks(3);
    phase = 32'hFFF00000;
    light_pulse = 1'b1;
    ticks(2);
    chk("finediff_early", valid_cnt, 0);
    tick();
    chk("finediff_tof", tof, 13'd100);
    ticks(2);
    start = 1'b0; light_pulse = 1'b0;
    ticks(4);
    chk("finediff_single", valid_cnt, 1);
    phase = 32'hFFFF0000;

    // rotating phase: pattern FFFF0000 at the start-processing edge
    rot_en = 1'b1;
    rot_idx = 5'd31;
    meas(110, 13'd3506, "rotate", 1'b0, 1'b0);
    rot_en = 1'b0;
    tick();
    phase = 32'hFFFF0000;
    tick();

    // second start during RUN ignored
    meas(50, 13'd1600, "restart", 1'b0, 1'b1);

    // coincident start and stop in IDLE: start wins
    meas(40, 13'd1280, "simul", 1'b1, 1'b0);

    // stop in IDLE ignored
    valid_cnt = 0;
    light_pulse = 1'b1;
    ticks(4);
    light_pulse = 1'b0;
    ticks(8);
    chk("idle_stop", valid_cnt, 0);

    // timeout: valid 255 cycles after start processing
    valid_cnt = 0;
    lat = -1;
    start = 1'b1;
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (i == 4) start = 1'b0;
      if (valid_cnt != 0) begin
        lat = i;
        break;
      end
    end
    chk("timeout_latency", lat, 258);
    chk("timeout_tof", tof, 13'h1FFF);
    valid_cnt = 0;
    light_pulse = 1'b1;
    ticks(4);
    light_pulse = 1'b0;
    ticks(6);
    chk("timeout_stop_ignored", valid_cnt, 0);
    chk("timeout_tof_hold", tof, 13'h1FFF);

    // reset mid-measurement aborts it
    valid_cnt = 0;
    start = 1'b1;
    ticks(4);
    start = 1'b0;
    ticks(16);
    rst = 1'b0;
    tick();
    chk("abort_tof", tof, 32'd0);
    chk("abort_valid", out_valid, 1'b0);
    ticks(2);
    rst = 1'b1;
    ticks(300);
    chk("abort_no_valid", valid_cnt, 0);

    chk("no_back_to_back", dbl_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/tdc_top_sync.md
# tdc_top_sync

Synchronous time-to-digital converter. It measures the interval from a `start` rising edge to a `light_pulse` (stop) rising edge. The measurement combines a coarse count of `clk` cycles with a fine 5-bit interpolation taken from a 32-tap phase vector. It sits between the laser-trigger/receiver front end and the range-processing logic, and emits one 13-bit time-of-flight word per measurement.

## Interface
- No parameters. Fixed widths: 32 phase taps, 8-bit coarse count, 5-bit fine code, 13-bit result.
- `clk` input 1: system clock; all state on rising edge.
- `rst` input 1: reset, asynchronous, active-low.
- `phase` input 32: thermometer snapshot of 32 equally spaced clock phases; one contiguous run of 1s.
- `start` input 1: asynchronous measurement start, level; rising edge is the event.
- `light_pulse` input 1: asynchronous stop (returned light), level; rising edge is the event.
- `tof` output 13: result `{coarse[7:0], fine[4:0]}`; LSB = Tclk/32.
- `out_valid` output 1: one-cycle pulse when `tof` is updated.

## Operation
- **Input synchronisation:** `start` and `light_pulse` each pass through a 2-flop synchroniser plus a third delay flop.
  - Event = sync2 & ~sync3 (rising edge).
- **Fine decode:** combinational, on the `phase` input.
  - fine = lowest index i in 0..31 with phase[i]=1 and phase[(i+31) mod 32]=0 (the wrap-aware start of the 1s run).
  - All-0s or all-1s gives fine = 0.
- **FSM states:** IDLE and RUN.
- **IDLE:**
  - On a start event: capture fine_start, set cnt = 1, go to RUN.
  - Stop events are ignored.
  - Simultaneous start and stop events: start wins, stop is dropped.
- **RUN, stop event:**
  - tof = ({cnt, 5'b0} + fine_stop − fine_start) mod 8192.
  - out_valid = 1, go to IDLE.
- **RUN, no stop and cnt = 255 (timeout):** tof = 13'h1FFF, out_valid = 1, go to IDLE.
- **RUN, otherwise:** cnt increments by 1 each cycle.
- Start events in RUN are ignored; no restart.
- `tof` holds its last value between results.
- **Reset values:** tof = 0, out_valid = 0, state = IDLE, cnt = 0, all synchroniser flops = 0.

## Timing
- An input rising edge first captured at posedge k is processed at posedge k+2. The result is registered at that same edge, so `out_valid` is high during cycle k+2..k+3.
- Start and stop paths have identical latency, so latency cancels in the difference.
- The phase snapshot is taken at the processing edge for both events.
- Minimum measurable interval is N = 1 cycle. A stop processed N cycles after the start yields coarse = N.
- `out_valid` is never high on two consecutive cycles.
- Asserting reset mid-measurement aborts it; no `out_valid` is produced.
- Inputs must stay stable ≥ 2 cycles, high and low, for an edge to be detected.

## Structure
- Shared package `tdc_pkg`:
  - Widths PHASE_W = 32, COARSE_W = 8, FINE_W = 5, TOF_W = 13.
  - Constant TOF_TIMEOUT = 13'h1FFF.
  - FSM state enum {IDLE, RUN}.
- One natural sub-module: `tdc_edge_sync` (2-flop synchroniser plus rising-edge detector), instantiated twice.
- The fine decoder is a function inside the top module.

## Test plan
- **Reset:** hold rst low with `start`/`light_pulse` toggling → tof = 0, out_valid = 0 throughout. After release, no `out_valid` appears without a start.
- **Static phase:** `phase` fixed at 32'hFFFF0000 (fine = 16), start rise then stop rise 110 cycles later → single `out_valid` pulse, tof = 3520.
- **Fine difference:** `phase` = 32'hFFFF0000 at the start-processing edge and 32'hFFF00000 (fine = 20) at the stop-processing edge, N = 3 → tof = 100.
- **Rotating phase:** reset pattern 32'hFFFF0000, rotated right one bit per cycle; start rise, stop rise 1100 ns (110 cycles) later → tof = 3506.
- **Timeout:** start with no stop → `out_valid` occurs 255 cycles after start processing, tof = 13'h1FFF. The next stop is ignored.
- **Ignored events:**
  - A stop in IDLE → no `out_valid`.
  - A second start during RUN → result still measured from the first start.
